// File: rtl/core_1553_pkg.sv
// core_1553_pkg: shared 1553 constants, decoder state encoding and default oversampling
package core_1553_pkg;
  localparam logic [5:0] SYNC_CSW = 6'b111_000;
  localparam logic [5:0] SYNC_DW  = 6'b000_111;
  localparam int SPB_DEF = 8;
  typedef enum logic [1:0] {IDLE, SYNC2, DATA, DONE} dec_state_e;
endpackage

// File: rtl/dec_1553_line_front.sv
// dec_1553_line_front: synchronizes the differential pair and measures run lengths of the line level
module dec_1553_line_front #(
  parameter int SPB = 8
) (
  input  logic                        dec_clk,
  input  logic                        rst_n,
  input  logic                        rx_data,
  input  logic                        rx_data_n,
  output logic                        line_vld,
  output logic                        line_lvl,
  output logic                        line_chg,
  output logic [$clog2(2*SPB+3)-1:0] run_cnt
);
  localparam int RW = $clog2(2*SPB+3);
  localparam logic [RW-1:0] RUN_MAX = RW'(2*SPB+2);
  logic [1:0] d_q, dn_q;
  logic lvl_q;
  logic [RW-1:0] run_q, run_d;
  assign line_vld = d_q[1] ^ dn_q[1];
  assign line_lvl = d_q[1];
  // a non-zero run_q means the previous sample was valid, so a differing level is a true transition
  assign line_chg = line_vld && run_q != '0 && line_lvl != lvl_q;
  assign run_cnt  = run_q;
  // run length of the level seen so far, restarted on transitions and cleared while the line is idle
  always_comb
    run_d = !line_vld ? '0 : (line_chg || run_q == '0) ? RW'(1) : (run_q == RUN_MAX) ? run_q : run_q + 1'b1;
  // two-flop synchronizers plus the run-length state
  always_ff @(posedge dec_clk or negedge rst_n)
    if (!rst_n) begin
      d_q   <= '0;
      dn_q  <= '0;
      lvl_q <= 1'b0;
      run_q <= '0;
    end else begin
      d_q   <= {d_q[0], rx_data};
      dn_q  <= {dn_q[0], rx_data_n};
      lvl_q <= line_lvl;
      run_q <= run_d;
    end
endmodule

// File: rtl/decoder_1553.sv
// decoder_1553: recovers 1553 words (sync type, 16 data bits, parity check) from an oversampled Manchester stream
module decoder_1553
  import core_1553_pkg::*;
#(
  parameter int SPB        = SPB_DEF,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic        dec_clk,
  input  logic        rst_n,
  input  logic        rx_data,
  input  logic        rx_data_n,
  output logic [0:15] rx_dword,
  output logic        rx_dval,
  output logic        rx_csw,
  output logic        rx_perr,
  output logic        rx_merr,
  output logic        rx_busy
);
  localparam int TW = $clog2(20*SPB);
  localparam int RW = $clog2(2*SPB+3);
  localparam logic [RW-1:0] SYNC_MIN = RW'(3*SPB/2 - SPB/4);
  localparam logic [RW-1:0] SYNC_MAX = RW'(2*SPB+1);
  localparam logic [TW-1:0] T_CHK  = TW'(3*SPB/4);
  localparam logic [TW-1:0] T_A0   = TW'(3*SPB/2 + SPB/4);
  localparam logic [TW-1:0] T_HALF = TW'(SPB/2);
  localparam logic [TW-1:0] T_BIT  = TW'(SPB);
  logic line_vld, line_lvl, line_chg;
  logic [RW-1:0] run_cnt;
  dec_state_e state_q;
  logic [TW-1:0] timer_q, nxt_a_q;
  logic sync_q, a_q;
  logic [4:0] bit_q;
  logic [16:0] sh_q, sh_d;
  logic [0:15] dword_q;
  logic dval_q, csw_q, perr_q, merr_q;
  logic sync_edge, hit_a, hit_b, half_ok;

  dec_1553_line_front #(.SPB(SPB)) u_front (
    .dec_clk   (dec_clk),
    .rst_n     (rst_n),
    .rx_data   (rx_data),
    .rx_data_n (rx_data_n),
    .line_vld  (line_vld),
    .line_lvl  (line_lvl),
    .line_chg  (line_chg),
    .run_cnt   (run_cnt)
  );

  assign sh_d      = {sh_q[15:0], a_q};
  assign sync_edge = line_chg && run_cnt >= SYNC_MIN && run_cnt <= SYNC_MAX;
  assign hit_a     = timer_q == nxt_a_q;
  assign hit_b     = timer_q == nxt_a_q + T_HALF;
  assign half_ok   = line_vld && line_lvl != a_q;
  assign rx_dword  = dword_q;
  assign rx_dval   = dval_q;
  assign rx_csw    = csw_q;
  assign rx_perr   = perr_q;
  assign rx_merr   = merr_q;
  assign rx_busy   = state_q != IDLE;

  // word FSM; timer_q holds the index of the sample being examined, with the sync mid-edge sample as index 0
  always_ff @(posedge dec_clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      timer_q <= '0;
      nxt_a_q <= '0;
      sync_q  <= 1'b0;
      a_q     <= 1'b0;
      bit_q   <= '0;
      sh_q    <= '0;
      dword_q <= '0;
      dval_q  <= 1'b0;
      csw_q   <= 1'b0;
      perr_q  <= 1'b0;
      merr_q  <= 1'b0;
    end else begin
      dval_q  <= 1'b0;
      merr_q  <= 1'b0;
      timer_q <= timer_q + 1'b1;
      case (state_q)
        IDLE:
          if (sync_edge) begin
            state_q <= SYNC2;
            sync_q  <= !line_lvl;
            timer_q <= TW'(1);
          end
        SYNC2:
          if (timer_q == T_CHK) begin
            state_q <= (line_vld && line_lvl != sync_q) ? DATA : IDLE;
            nxt_a_q <= T_A0;
            bit_q   <= '0;
          end
        DATA:
          if (hit_a) begin
            a_q <= line_lvl;
            if (!line_vld) begin
              merr_q  <= 1'b1;
              state_q <= IDLE;
            end
          end else if (hit_b) begin
            if (!half_ok) begin
              merr_q  <= 1'b1;
              state_q <= IDLE;
            end else begin
              sh_q    <= sh_d;
              nxt_a_q <= nxt_a_q + T_BIT;
              bit_q   <= bit_q + 1'b1;
              if (bit_q == 5'd16) begin
                state_q <= DONE;
                dval_q  <= 1'b1;
                dword_q <= sh_d[16:1];
                csw_q   <= sync_q;
                perr_q  <= (^sh_d) != PARITY_ODD;
              end
            end
          end
        DONE:
          state_q <= IDLE;
        default:
          state_q <= IDLE;
      endcase
    end
endmodule

// File: doc/decoder_1553.md
Name: decoder_1553

Overview:
- Receive-side counterpart of the 1553 encoder.
- Consumes the differential Manchester serial stream (data/data_n pair, both low when idle) and recovers each word: its sync type (command/status or data), the 16-bit word and a parity check.
- Runs on an oversampling clock and sits between the bus transceiver receive pins and the protocol/RT logic.

Parameters:
- SPB, 8: dec_clk samples per 1553 bit time. Must be even and ≥8. Default gives an 8 MHz dec_clk for 1 Mb/s.
- PARITY_ODD, 0: required XOR of {word, parity}. The default 0 matches the encoder's even parity (XOR of the 16 data bits); set 1 for strict MIL-STD odd parity.

Ports:
- dec_clk  in  1  oversampling clock (SPB × bit rate)
- rst_n  in  1  asynchronous active-low reset
- rx_data  in  1  serial Manchester input, true line (asynchronous to dec_clk)
- rx_data_n  in  1  serial Manchester input, complement line (asynchronous)
- rx_dword  out  [0:15]  received word; bit 0 is the first bit received (MSB)
- rx_dval  out  1  one-cycle pulse: rx_dword, rx_csw and rx_perr have just been updated
- rx_csw  out  1  1 = command/status sync (high-then-low), 0 = data sync (low-then-high); held until the next rx_dval
- rx_perr  out  1  parity result for the current rx_dword; held until the next rx_dval
- rx_merr  out  1  one-cycle pulse: word aborted on a Manchester or idle error
- rx_busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset (asynchronous, active-low): all outputs are 0, FSM goes to IDLE, and the synchronizers, counters and timer clear.
- Front end:
  - 2-FF synchronizer on each of rx_data and rx_data_n.
  - line_vld = (d != d_n); line_lvl = d.
  - run_cnt counts consecutive samples with line_vld=1 and the same level. It saturates at 2·SPB+2. It resets to 1 on a level change and to 0 when line_vld=0. It runs in every state.
- Sync window: SYNC_MIN = 3·SPB/2 − SPB/4 (10), SYNC_MAX = 2·SPB+1 (17). The upper bound absorbs the trailing parity half-bit of a back-to-back word plus 1 sample of jitter.
- IDLE:
  - A level change while run_cnt (previous run) is in [SYNC_MIN, SYNC_MAX] is the sync edge. Latch sync_type = previous level (1 → csw).
  - Clear timer to 0 on the edge sample and go to SYNC2.
  - Runs outside the window are ignored.
- SYNC2:
  - timer increments each cycle.
  - At timer = 3·SPB/4 (6) the sample must be valid and equal to the new level; if so, go to DATA, otherwise go silently to IDLE with no pulse.
- DATA, for bits k = 0..16:
  - Sample half A at timer = 3·SPB/2 + k·SPB + SPB/4.
  - Sample half B at timer = 3·SPB/2 + k·SPB + 3·SPB/4.
  - Bit value = A.
  - A == B, or line_vld = 0 at either sample: pulse rx_merr, go to IDLE, leave rx_dword/rx_csw/rx_perr unchanged.
  - Shift bits into a 17-bit register, MSB first.
- DONE (1 cycle after the parity half-B sample; timer = 147 for SPB=8):
  - rx_dval = 1.
  - rx_dword = bits[0:15].
  - rx_csw = sync_type.
  - rx_perr = (^bits[0:16] != PARITY_ODD).
  - Go to IDLE on the next cycle.
- Timer width: clog2(20·SPB).
- Latency: rx_dval occurs 147 dec_clk cycles after the synchronized sync mid-edge for SPB=8, i.e. 3·SPB/2 + 16·SPB + 3·SPB/4 + 1 in general.
- Back-to-back words with no gap are decoded. No bus dead-time is required.
- rx_merr and rx_dval are never asserted in the same cycle.
- Data content cannot form a valid sync: a maximum run of SPB samples is below SYNC_MIN.

Decomposition:
- Shared package core_1553_pkg holds:
  - sync pattern constants (SYNC_CSW = 6'b111_000, SYNC_DW = 6'b000_111), also used by encoder_1553;
  - FSM state encodings (IDLE, SYNC2, DATA, DONE);
  - the default SPB.
- One sub-module: dec_1553_line_front. It holds the 2-FF synchronizers, line_vld/line_lvl, and run_cnt with the level-change flag.

Test Plan:
- CSW sync + 16'h1234 + parity 1 (5 ones, PARITY_ODD=0), SPB=8 → one rx_dval 147 cycles after the sync mid-edge; rx_dword=16'h1234, rx_csw=1, rx_perr=0, rx_merr=0.
- DW sync + 16'hFFFF + parity 0 → rx_dval, rx_dword=16'hFFFF, rx_csw=0, rx_perr=0.
- DW sync + 16'h0001 with parity bit inverted (0) → rx_dval, rx_dword=16'h0001, rx_perr=1.
- CSW word with bit 7 driven high for both halves → rx_merr pulse at the bit-7 half-B sample, no rx_dval, rx_busy=0 next cycle, rx_dword unchanged.
- Two words back-to-back (CSW 16'hA5A5, then DW 16'h5A5A), no gap → two rx_dval pulses exactly 160 cycles apart with the correct csw/data flags. A sync first half of only 8 samples → no output.
- rst_n asserted at bit 9 of a word → all outputs 0 immediately, no pulses. After release, the next complete word decodes correctly.
